// File: rtl/return_pkg.sv
// Shared types and widths for the return packer: FSM states, accumulator and byte sizes.
// Count is one bit wider than a nibble so that a flush from 13 valid bits can pad to 16.
package return_pkg;
  localparam int ACC_W  = 16;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    PUSH  = 1'b1
  } state_t;
endpackage

// File: rtl/return_fifo.sv
// First-word-fall-through byte queue: head visible the edge after the write lands, zero when empty.
// Backpressure: wr_rdy drops when full unless the head is being popped on the same edge.
module return_fifo
  import return_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [BYTE_W-1:0] wr_dat,
  output logic              wr_rdy,
  output logic              rd_vld,
  output logic [BYTE_W-1:0] rd_dat,
  input  logic              rd_rdy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              push;
  logic              pop;

  assign rd_vld = (occ != '0);
  assign wr_rdy = (occ != FULL_OCC) || (rd_vld && rd_rdy);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers are PTR_W bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/return_packer.sv
// Packs 1-bit and 5-bit child returns LSB-first into bytes; a completed byte reaches the output two edges after its last bit.
// Backpressure: in_ready low while a full byte waits in the accumulator; a full FIFO stalls the push.
module return_packer
  import return_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              _clock,
  input  logic              _reset,
  input  logic              i,
  input  logic              i_valid,
  input  logic [4:0]        bus_i,
  input  logic              bus_valid,
  input  logic              flush,
  output logic              in_ready,
  output logic [BYTE_W-1:0] return_dat,
  output logic              return_par,
  output logic              return_valid,
  input  logic              out_ready
);
  localparam logic [CNT_W-1:0] ONE_BYTE  = CNT_W'(BYTE_W);
  localparam logic [CNT_W-1:0] TWO_BYTES = CNT_W'(2 * BYTE_W);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] add_val;
  logic [CNT_W-1:0] add_len;
  logic [CNT_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_new;
  logic             push_rdy;

  // Bus bits land first, the single bit sits just above them.
  always_comb begin
    add_val = '0;
    add_len = '0;
    if (bus_valid) begin
      add_val = ACC_W'(bus_i);
      add_len = CNT_W'(5);
      if (i_valid) begin
        add_val = ACC_W'({i, bus_i});
        add_len = CNT_W'(6);
      end
    end else if (i_valid) begin
      add_val = ACC_W'(i);
      add_len = CNT_W'(1);
    end
    cnt_sum = cnt + add_len;
    cnt_new = cnt_sum;
    if (flush && (cnt_sum[2:0] != 3'd0)) cnt_new = {cnt_sum[CNT_W-1:3] + 1'b1, 3'b000};
  end

  // Bits above cnt are always zero, so OR-in and zero-padding need no masking.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          acc <= acc | (add_val << cnt[2:0]);
          cnt <= cnt_new;
          if (cnt_new >= ONE_BYTE) begin
            state    <= PUSH;
            in_ready <= 1'b0;
          end
        end
        PUSH: begin
          if (push_rdy) begin
            acc <= acc >> BYTE_W;
            cnt <= cnt - ONE_BYTE;
            if (cnt < TWO_BYTES) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  return_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (_clock),
    .rst    (_reset),
    .wr_vld (state == PUSH),
    .wr_dat (acc[BYTE_W-1:0]),
    .wr_rdy (push_rdy),
    .rd_vld (return_valid),
    .rd_dat (return_dat),
    .rd_rdy (out_ready)
  );

  assign return_par = ^return_dat;
endmodule

// File: tb/tb_return_packer.sv
// Bench for return_packer: directed scenarios plus random traffic against a bit-queue reference model.
module tb_return_packer;
  logic       clk;
  logic       rst;
  logic       i, i_valid, bus_valid, flush, out_ready;
  logic [4:0] bus_i;
  logic       in_ready, return_valid, return_par;
  logic [7:0] return_dat;

  int ncmp  = 0;
  int nfail = 0;
  int npop  = 0;

  bit         bitq[$];
  logic [7:0] expq[$];

  return_packer #(.DEPTH(4)) dut (
    ._clock       (clk),
    ._reset       (rst),
    .i            (i),
    .i_valid      (i_valid),
    .bus_i        (bus_i),
    .bus_valid    (bus_valid),
    .flush        (flush),
    .in_ready     (in_ready),
    .return_dat   (return_dat),
    .return_par   (return_par),
    .return_valid (return_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: accepted bits in arrival order, cut into bytes eight at a time.
  task automatic model_accept(input logic iv, input logic ii, input logic bv,
                              input logic [4:0] bb, input logic fl);
    logic [7:0] b;
    if (bv) for (int k = 0; k < 5; k++) bitq.push_back(bb[k]);
    if (iv) bitq.push_back(ii);
    if (fl) while (bitq.size() % 8 != 0) bitq.push_back(1'b0);
    while (bitq.size() >= 8) begin
      for (int k = 0; k < 8; k++) b[k] = bitq.pop_front();
      expq.push_back(b);
    end
  endtask

  task automatic check_pop();
    logic [7:0] e;
    chk("pop_expected", 32'(expq.size() > 0), 32'd1);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("pop_data", return_dat, e);
      chk("pop_par", return_par, ^e);
    end
    npop++;
  endtask

  // Called just after a falling edge; returns after the next falling edge.
  task automatic drive(input logic iv, input logic ii, input logic bv, input logic [4:0] bb,
                       input logic fl, input logic ordy, input logic rst_in, output logic accepted);
    i_valid = iv; i = ii; bus_valid = bv; bus_i = bb; flush = fl;
    out_ready = ordy; rst = rst_in;
    accepted = in_ready && !rst_in;
    if (rst_in) begin
      bitq.delete();
      expq.delete();
    end else begin
      if (accepted) model_accept(iv, ii, bv, bb, fl);
      if (return_valid && ordy) check_pop();
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, ordy, 1'b0, a);
  endtask

  task automatic send(input logic iv, input logic ii, input logic bv, input logic [4:0] bb,
                      input logic fl, input logic ordy);
    logic a;
    int n;
    n = 0;
    do begin
      drive(iv, ii, bv, bb, fl, ordy, 1'b0, a);
      n++;
    end while (!a && n < 50);
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bits(input logic [63:0] v, input int nb, input logic ordy);
    int pos;
    pos = 0;
    while (nb - pos >= 6) begin
      send(1'b1, v[pos+5], 1'b1, v[pos+:5], 1'b0, ordy);
      pos += 6;
    end
    while (pos < nb) begin
      send(1'b1, v[pos], 1'b0, 5'd0, 1'b0, ordy);
      pos++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() > 0 || return_valid) && n < 200) begin
      idle(1'b1);
      n++;
    end
    chk("drain_model_empty", expq.size(), 32'd0);
    chk("drain_valid_low", return_valid, 1'b0);
  endtask

  initial begin
    logic       a;
    logic [7:0] pat;
    logic       r_iv, r_i, r_bv, r_fl, r_or;
    logic [4:0] r_bus;
    int         pop_mark;

    rst = 1'b1; i = 0; i_valid = 0; bus_i = '0; bus_valid = 0; flush = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_valid", return_valid, 1'b0);
    chk("rst_dat", return_dat, 8'h00);
    chk("rst_par", return_par, 1'b0);

    // Eight single bits, LSB first.
    pat = 8'b1000_1101;
    for (int k = 0; k < 8; k++) send(1'b1, pat[k], 1'b0, 5'd0, 1'b0, 1'b0);
    chk("b8_valid_not_yet", return_valid, 1'b0);
    idle(1'b0);
    chk("b8_valid", return_valid, 1'b1);
    chk("b8_dat", return_dat, 8'h8D);
    chk("b8_par", return_par, 1'b0);
    drain();

    // Bus plus bit in one cycle, then another bus word: 11 bits.
    send(1'b1, 1'b1, 1'b1, 5'h1F, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0);
    chk("b11_in_ready_low", in_ready, 1'b0);
    chk("b11_cnt", dut.cnt, 32'd11);
    idle(1'b0);
    chk("b11_in_ready_back", in_ready, 1'b1);
    chk("b11_dat", return_dat, 8'h3F);
    chk("b11_cnt_left", dut.cnt, 32'd3);
    send(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    drain();

    // Three ones then flush; a flush on an empty accumulator adds nothing.
    for (int k = 0; k < 3; k++) send(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(1'b0);
    chk("fl_valid", return_valid, 1'b1);
    chk("fl_dat", return_dat, 8'h07);
    chk("fl_cnt", dut.cnt, 32'd0);
    drain();
    send(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    repeat (3) idle(1'b0);
    chk("fl0_no_byte", return_valid, 1'b0);
    chk("fl0_cnt", dut.cnt, 32'd0);
    chk("fl0_in_ready", in_ready, 1'b1);

    // Five bytes against a stalled consumer, then pop while the fifth waits.
    send_bits(64'h00_00_00_C4_77_3E_5C_A1, 40, 1'b0);
    repeat (3) idle(1'b0);
    chk("full_occ", dut.u_fifo.occ, 32'd4);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_head", return_dat, 8'hA1);
    chk("full_held_cnt", dut.cnt, 32'd8);
    pop_mark = npop;
    idle(1'b1);
    chk("pushpop_occ", dut.u_fifo.occ, 32'd4);
    chk("pushpop_in_ready", in_ready, 1'b1);
    chk("pushpop_head", return_dat, 8'h5C);
    drain();
    chk("five_popped", npop - pop_mark, 32'd5);

    // Reset mid-operation with queued and partial data.
    send_bits(64'h0000_0000_0015_B3E9, 21, 1'b0);
    repeat (2) idle(1'b0);
    chk("pre_rst_occ", dut.u_fifo.occ, 32'd2);
    chk("pre_rst_cnt", dut.cnt, 32'd5);
    drive(1'b1, 1'b1, 1'b1, 5'h1F, 1'b1, 1'b1, 1'b1, a);
    chk("mid_rst_valid", return_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_dat", return_dat, 8'h00);
    send_bits(64'h96, 8, 1'b0);
    idle(1'b0);
    chk("post_rst_valid", return_valid, 1'b1);
    chk("post_rst_dat", return_dat, 8'h96);
    drain();

    // Random traffic; producers hold values until accepted.
    pop_mark = npop;
    r_iv = 1'($urandom); r_i = 1'($urandom); r_bv = 1'($urandom);
    r_bus = 5'($urandom); r_fl = ($urandom_range(0, 9) == 0);
    for (int c = 0; c < 600; c++) begin
      r_or = ($urandom_range(0, 9) < 7);
      drive(r_iv, r_i, r_bv, r_bus, r_fl, r_or, 1'b0, a);
      if (a) begin
        r_iv = 1'($urandom); r_i = 1'($urandom); r_bv = 1'($urandom);
        r_bus = 5'($urandom); r_fl = ($urandom_range(0, 9) == 0);
      end
    end
    send(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    drain();
    chk("rand_bytes_seen", 32'(npop - pop_mark > 20), 32'd1);
    chk("rand_bits_left", bitq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
